id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and flush handling. It sits between the decode stage and the EX stage. It captures decoded operands and control each cycle and presents rs1_ex/rs2_ex/rd_ex to the EX-stage forwarding logic. It stalls PC and IF/ID for one cycle when a load result cannot be forwarded in time. Saturating stall and flush counters support performance analysis.

---
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush squashing and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rd_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [DATA_W-1:0] reg_data_1_id,
  input  logic [DATA_W-1:0] reg_data_2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [1:0]        alu_op_id,
  input  logic              alu_src_id,
  input  logic              mem_read_id,
  input  logic              mem_write_id,
  input  logic              mem_2_reg_id,
  input  logic              reg_write_id,
  input  logic              branch_id,
  input  logic              valid_id,
  input  logic              flush,
  input  logic              stall_ext,
  input  logic              clear_cnt,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic [DATA_W-1:0] reg_data_1_ex,
  output logic [DATA_W-1:0] reg_data_2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [1:0]        alu_op_ex,
  output logic              alu_src_ex,
  output logic              mem_read_ex,
  output logic              mem_write_ex,
  output logic              mem_2_reg_ex,
  output logic              reg_write_ex,
  output logic              branch_ex,
  output logic              valid_ex,
  output logic              hazard,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic                   load_bubble;
  logic                   stall_ev;
  logic [1:0]             cnt_inc;
  logic [1:0][CNT_W-1:0]  cnt_val;

  // Loads to x0 are excluded via rd_ex != 0, which also keeps bubbles inert.
  assign hazard = valid_ex & mem_read_ex & (rd_ex != 5'd0) & valid_id &
                  ((use_rs1_id & (rs1_id == rd_ex)) |
                   (use_rs2_id & (rs2_id == rd_ex)));

  assign pc_write    = !(stall_ext | (hazard & !flush));
  assign if_id_write = pc_write;

  assign stall_ev    = hazard & !flush & !stall_ext;
  assign load_bubble = flush | stall_ev;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      {rs1_ex, rs2_ex, rd_ex, reg_data_1_ex, reg_data_2_ex, imm_ex, pc_ex,
       alu_op_ex, alu_src_ex, mem_read_ex, mem_write_ex, mem_2_reg_ex,
       reg_write_ex, branch_ex, valid_ex} <= '0;
    end else if (load_bubble) begin
      {rs1_ex, rs2_ex, rd_ex, reg_data_1_ex, reg_data_2_ex, imm_ex, pc_ex,
       alu_op_ex, alu_src_ex, mem_read_ex, mem_write_ex, mem_2_reg_ex,
       reg_write_ex, branch_ex, valid_ex} <= '0;
    end else if (!stall_ext) begin
      {rs1_ex, rs2_ex, rd_ex, reg_data_1_ex, reg_data_2_ex, imm_ex, pc_ex,
       alu_op_ex, alu_src_ex, mem_read_ex, mem_write_ex, mem_2_reg_ex,
       reg_write_ex, branch_ex, valid_ex} <=
      {rs1_id, rs2_id, rd_id, reg_data_1_id, reg_data_2_id, imm_id, pc_id,
       alu_op_id, alu_src_id, mem_read_id, mem_write_id, mem_2_reg_id,
       reg_write_id, branch_id, valid_id};
    end
  end

  // Index 0 counts load-use stalls, index 1 counts flushes.
  assign cnt_inc = {flush, stall_ev};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cnt_reg <= '0;
        end else if (clear_cnt) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && !(&cnt_reg)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued as each
// ID slot is driven and popped after the capturing edge.
module tb_id_ex_stage;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic [4:0]        rs1, rs2, rd;
    logic [DATA_W-1:0] d1, d2, imm, pc;
    logic [1:0]        alu_op;
    logic              alu_src, mem_read, mem_write, mem_2_reg, reg_write, branch, valid;
  } ex_t;

  logic clk, arst_n;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic use_rs1_id, use_rs2_id;
  logic [DATA_W-1:0] reg_data_1_id, reg_data_2_id, imm_id, pc_id;
  logic [1:0] alu_op_id;
  logic alu_src_id, mem_read_id, mem_write_id, mem_2_reg_id, reg_write_id, branch_id, valid_id;
  logic flush, stall_ext, clear_cnt;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  logic [DATA_W-1:0] reg_data_1_ex, reg_data_2_ex, imm_ex, pc_ex;
  logic [1:0] alu_op_ex;
  logic alu_src_ex, mem_read_ex, mem_write_ex, mem_2_reg_ex, reg_write_ex, branch_ex, valid_ex;
  logic hazard, pc_write, if_id_write;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ex_t sb[$];
  ex_t got, exp, ld, cons;
  logic [CNT_W-1:0] exp_cnt;
  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .reg_data_1_id(reg_data_1_id), .reg_data_2_id(reg_data_2_id),
    .imm_id(imm_id), .pc_id(pc_id), .alu_op_id(alu_op_id),
    .alu_src_id(alu_src_id), .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
    .mem_2_reg_id(mem_2_reg_id), .reg_write_id(reg_write_id), .branch_id(branch_id),
    .valid_id(valid_id), .flush(flush), .stall_ext(stall_ext), .clear_cnt(clear_cnt),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .reg_data_1_ex(reg_data_1_ex), .reg_data_2_ex(reg_data_2_ex),
    .imm_ex(imm_ex), .pc_ex(pc_ex), .alu_op_ex(alu_op_ex),
    .alu_src_ex(alu_src_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .mem_2_reg_ex(mem_2_reg_ex), .reg_write_ex(reg_write_ex), .branch_ex(branch_ex),
    .valid_ex(valid_ex), .hazard(hazard), .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  function automatic ex_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic is_load);
    ex_t t;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.d1 = {$urandom, $urandom};
    t.d2 = {$urandom, $urandom};
    t.imm = {$urandom, $urandom};
    t.pc = {32'h0, $urandom} & ~64'h3;
    t.alu_op = is_load ? 2'b00 : 2'b10;
    t.alu_src = is_load;
    t.mem_read = is_load;
    t.mem_write = 1'b0;
    t.mem_2_reg = is_load;
    t.reg_write = 1'b1;
    t.branch = 1'b0;
    t.valid = 1'b1;
    return t;
  endfunction

  function automatic ex_t ex_now();
    return {rs1_ex, rs2_ex, rd_ex, reg_data_1_ex, reg_data_2_ex, imm_ex, pc_ex,
            alu_op_ex, alu_src_ex, mem_read_ex, mem_write_ex, mem_2_reg_ex,
            reg_write_ex, branch_ex, valid_ex};
  endfunction

  task automatic drive(input ex_t i, input logic u1, input logic u2,
                       input logic fl, input logic se, input logic cc);
    rs1_id = i.rs1; rs2_id = i.rs2; rd_id = i.rd;
    reg_data_1_id = i.d1; reg_data_2_id = i.d2; imm_id = i.imm; pc_id = i.pc;
    alu_op_id = i.alu_op; alu_src_id = i.alu_src; mem_read_id = i.mem_read;
    mem_write_id = i.mem_write; mem_2_reg_id = i.mem_2_reg;
    reg_write_id = i.reg_write; branch_id = i.branch; valid_id = i.valid;
    use_rs1_id = u1; use_rs2_id = u2;
    flush = fl; stall_ext = se; clear_cnt = cc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0t rd_ex=%0d valid_ex=%b mem_read_ex=%b stall_cnt=%0d flush_cnt=%0d",
             $time, rd_ex, valid_ex, mem_read_ex, stall_cnt, flush_cnt);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    sb.push_back('0);
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL reset_ctl hz/pcw/ifw got=%b exp=011", {hazard, pc_write, if_id_write});
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk) arst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      cons = mk(5'(k), 5'(k + 8), 5'(k + 16), 1'b0);
      drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({hazard, pc_write, if_id_write} !== 3'b011) begin
        n_err++; $display("FAIL b2b_ctl k=%0d got=%b exp=011", k, {hazard, pc_write, if_id_write});
      end
      sb.push_back(cons);
      tick();
      got = ex_now(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL b2b_ex k=%0d got=%h exp=%h", k, got, exp); end
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_err++; $display("FAIL b2b_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    ld = mk(5'd5, 5'd1, 5'd2, 1'b1);
    drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(ld);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL lu_load_ex got=%h exp=%h", got, exp); end
    cons = mk(5'd6, 5'd1, 5'd5, 1'b0);
    drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b100) begin
      n_err++; $display("FAIL lu_stall_ctl got=%b exp=100", {hazard, pc_write, if_id_write});
    end
    sb.push_back('0);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL lu_bubble_ex got=%h exp=%h", got, exp); end
    drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL lu_release_ctl got=%b exp=011", {hazard, pc_write, if_id_write});
    end
    sb.push_back(cons);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL lu_consumer_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if (stall_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_load_x0();
    ld = mk(5'd0, 5'd2, 5'd3, 1'b1);
    drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sb.push_back(ld);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL x0_load_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if (stall_cnt !== '0) begin n_err++; $display("FAIL x0_clear got=%0d exp=0", stall_cnt); end
    cons = mk(5'd8, 5'd0, 5'd4, 1'b0);
    drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL x0_ctl got=%b exp=011", {hazard, pc_write, if_id_write});
    end
    sb.push_back(cons);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL x0_consumer_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if (stall_cnt !== '0) begin n_err++; $display("FAIL x0_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_rs2_unused();
    ld = mk(5'd7, 5'd1, 5'd1, 1'b1);
    drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(ld);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rs2u_load_ex got=%h exp=%h", got, exp); end
    cons = mk(5'd9, 5'd3, 5'd7, 1'b0);
    drive(cons, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL rs2u_ctl got=%b exp=011", {hazard, pc_write, if_id_write});
    end
    sb.push_back(cons);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rs2u_consumer_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if (stall_cnt !== '0) begin n_err++; $display("FAIL rs2u_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_flush_hazard();
    ld = mk(5'd9, 5'd1, 5'd1, 1'b1);
    drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sb.push_back(ld);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL fl_load_ex got=%h exp=%h", got, exp); end
    cons = mk(5'd10, 5'd9, 5'd2, 1'b0);
    drive(cons, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b111) begin
      n_err++; $display("FAIL fl_ctl got=%b exp=111", {hazard, pc_write, if_id_write});
    end
    sb.push_back('0);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL fl_bubble_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {CNT_W'(0), CNT_W'(1)}) begin
      n_err++; $display("FAIL fl_cnt stall/flush got=%0d/%0d exp=0/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int p = 1; p <= 5; p++) begin
      ld = mk(5'd12, 5'd1, 5'd1, 1'b1);
      drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, (p == 1));
      sb.push_back(ld);
      tick();
      got = ex_now(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL sat_load_ex p=%0d got=%h exp=%h", p, got, exp); end
      cons = mk(5'd13, 5'd12, 5'd12, 1'b0);
      drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({hazard, pc_write} !== 2'b10) begin
        n_err++; $display("FAIL sat_stall_ctl p=%0d got=%b exp=10", p, {hazard, pc_write});
      end
      sb.push_back('0);
      tick();
      got = ex_now(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL sat_bubble_ex p=%0d got=%h exp=%h", p, got, exp); end
      drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      sb.push_back(cons);
      tick();
      got = ex_now(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL sat_consumer_ex p=%0d got=%h exp=%h", p, got, exp); end
      exp_cnt = (p < 3) ? CNT_W'(p) : CNT_W'(3);
      n_cmp++;
      if (stall_cnt !== exp_cnt) begin
        n_err++; $display("FAIL sat_stall_cnt p=%0d got=%0d exp=%0d", p, stall_cnt, exp_cnt);
      end
    end
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back('0);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL sat_idle_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_err++; $display("FAIL sat_clear got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_stall_ext();
    ld = mk(5'd14, 5'd1, 5'd1, 1'b1);
    drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(ld);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL se_load_ex got=%h exp=%h", got, exp); end
    cons = mk(5'd15, 5'd14, 5'd3, 1'b0);
    for (int s = 0; s < 3; s++) begin
      drive(cons, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({hazard, pc_write, if_id_write} !== 3'b100) begin
        n_err++; $display("FAIL se_hold_ctl s=%0d got=%b exp=100", s, {hazard, pc_write, if_id_write});
      end
      sb.push_back(ld);
      tick();
      got = ex_now(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL se_frozen_ex s=%0d got=%h exp=%h", s, got, exp); end
      n_cmp++;
      if (stall_cnt !== '0) begin n_err++; $display("FAIL se_hold_cnt s=%0d got=%0d exp=0", s, stall_cnt); end
    end
    drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({hazard, pc_write} !== 2'b10) begin
      n_err++; $display("FAIL se_release_ctl got=%b exp=10", {hazard, pc_write});
    end
    sb.push_back('0);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL se_bubble_ex got=%h exp=%h", got, exp); end
    drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(cons);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL se_consumer_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if (stall_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL se_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    ld = mk(5'd16, 5'd1, 5'd1, 1'b1);
    drive(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(ld);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rst_load_ex got=%h exp=%h", got, exp); end
    cons = mk(5'd17, 5'd16, 5'd16, 1'b0);
    drive(cons, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL rst_pre_hazard got=%b exp=1", hazard); end
    arst_n = 1'b0;
    #1;
    sb.push_back('0);
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rst_async_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if ({hazard, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL rst_async_ctl got=%b exp=011", {hazard, pc_write, if_id_write});
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_err++; $display("FAIL rst_async_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk) arst_n = 1'b1;
    sb.push_back(cons);
    tick();
    got = ex_now(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rst_consumer_ex got=%h exp=%h", got, exp); end
    n_cmp++;
    if (stall_cnt !== '0) begin n_err++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_load_x0();
    test_rs2_unused();
    test_flush_hazard();
    test_saturation();
    test_stall_ext();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
